// File: rtl/imm_extend_if.sv
// Valid/ready bundle for the immediate-extension stage: decode-side input
// handshake and operand-side output handshake.
interface imm_extend_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
);
  logic [IN_WIDTH-1:0]  imm;
  logic [1:0]           mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] ext;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output imm, mode, in_valid, out_ready,
    input  in_ready, ext, out_valid
  );

  modport slave (
    input  imm, mode, in_valid, out_ready,
    output in_ready, ext, out_valid
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined sign/zero immediate extension with optional left shift, buffered
// by an output register plus a skid register so in_ready can be registered.
module imm_extend_pipe #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  imm_extend_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t               state_reg, state_next;
  logic [OUT_WIDTH-1:0] out_reg, out_next;
  logic [OUT_WIDTH-1:0] skid_reg, skid_next;
  logic                 in_ready_reg;
  logic [OUT_WIDTH-1:0] ext_bits;
  logic [OUT_WIDTH-1:0] result;
  logic                 out_valid;
  logic                 in_xfer;
  logic                 out_xfer;

  // Upper bits carry the sign bit only for the sign-extending modes (mode[0]=0).
  generate
    for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_ext
      if (gi < IN_WIDTH) begin : g_low
        assign ext_bits[gi] = bus.imm[gi];
      end else begin : g_high
        assign ext_bits[gi] = ~bus.mode[0] & bus.imm[IN_WIDTH-1];
      end
    end
  endgenerate

  assign result    = bus.mode[1] ? (ext_bits << SHIFT) : ext_bits;
  assign out_valid = (state_reg != EMPTY);
  assign in_xfer   = bus.in_valid && in_ready_reg;
  assign out_xfer  = out_valid && bus.out_ready;

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          out_next   = result;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          out_next = result;
        end else if (in_xfer) begin
          skid_next  = result;
          state_next = TWO;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain path is possible.
        if (bus.out_ready) begin
          out_next   = skid_reg;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      out_reg      <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      out_reg      <= out_next;
      skid_reg     <= skid_next;
      in_ready_reg <= (state_next != TWO);
    end
  end

  assign bus.ext       = out_reg;
  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready_reg;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: default 8->32 shift-2 instance plus a
// 12->16 shift-4 instance for the parameter sweep.
module tb_imm_extend_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_extend_if #(.IN_WIDTH(8),  .OUT_WIDTH(32)) ifc ();
  imm_extend_if #(.IN_WIDTH(12), .OUT_WIDTH(16)) ifc_w ();

  imm_extend_pipe #(.IN_WIDTH(8), .OUT_WIDTH(32), .SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );
  imm_extend_pipe #(.IN_WIDTH(12), .OUT_WIDTH(16), .SHIFT(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(ifc_w)
  );

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] sb[$];
  logic [15:0] sb_w[$];
  logic [31:0] exp;

  function automatic logic [31:0] model(input logic [7:0] d, input logic [1:0] m);
    logic [31:0] v;
    v = m[0] ? {24'h0, d} : {{24{d[7]}}, d};
    if (m[1]) v = {v[29:0], 2'b00};
    return v;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m, input logic r);
    ifc.in_valid  = v;
    ifc.imm       = d;
    ifc.mode      = m;
    ifc.out_ready = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 2'b00, 1'b0);
    ifc_w.in_valid = 1'b0; ifc_w.imm = '0; ifc_w.mode = 2'b00; ifc_w.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (ifc.ext !== 32'h0) begin mismatched++; $display("FAIL reset_out: got %h want 00000000", ifc.ext); end
    compared++; if (ifc.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
    compared++; if (ifc.in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 8'hAA, 2'b01, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h55, 2'b01, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 2'b00, 1'b0);
    compared++; if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1) begin mismatched++; $display("FAIL reset_fill_two: in_ready=%b out_valid=%b want 0/1", ifc.in_ready, ifc.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (ifc.ext !== 32'h0) begin mismatched++; $display("FAIL async_reset_out: got %h want 00000000", ifc.ext); end
    compared++; if (ifc.out_valid !== 1'b0) begin mismatched++; $display("FAIL async_reset_out_valid: got %b want 0", ifc.out_valid); end
    compared++; if (ifc.in_ready !== 1'b1) begin mismatched++; $display("FAIL async_reset_in_ready: got %b want 1", ifc.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    drive(1'b0, 8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++; if (ifc.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_skid_discarded: out_valid=%b out=%h want 0", ifc.out_valid, ifc.ext); end
    end
  endtask

  task automatic test_modes();
    logic [7:0]  d_t[5] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'hFC};
    logic [1:0]  m_t[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] e_t[5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFE00, 32'h00000200, 32'hFFFFFFF0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, d_t[i], m_t[i], 1'b1);
      if (ifc.in_ready) sb.push_back(e_t[i]);
      @(negedge clk);
      drive(1'b0, 8'h00, 2'b00, 1'b1);
      compared++; if (ifc.out_valid !== 1'b1) begin mismatched++; $display("FAIL mode%0d_latency: out_valid=%b want 1", i, ifc.out_valid); end
      if (ifc.out_valid && ifc.out_ready) begin
        compared++;
        if (sb.size() == 0) begin mismatched++; $display("FAIL mode%0d_extra: got %h want no output", i, ifc.ext); end
        else begin exp = sb.pop_front(); if (ifc.ext !== exp) begin mismatched++; $display("FAIL mode%0d_value: got %h want %h", i, ifc.ext, exp); end end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) drive(1'b1, 8'($urandom), 2'($urandom), 1'b1);
      else        drive(1'b0, 8'h00, 2'b00, 1'b1);
      if (i < 16) begin
        compared++; if (ifc.in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, ifc.in_ready); end
      end
      compared++;
      if (ifc.out_valid !== (i >= 1 && i <= 16)) begin mismatched++; $display("FAIL stream_out_valid[%0d]: got %b want %b", i, ifc.out_valid, (i >= 1 && i <= 16)); end
      if (ifc.out_valid && ifc.out_ready) begin
        compared++;
        if (sb.size() == 0) begin mismatched++; $display("FAIL stream_extra[%0d]: got %h want no output", i, ifc.ext); end
        else begin exp = sb.pop_front(); if (ifc.ext !== exp) begin mismatched++; $display("FAIL stream_value[%0d]: got %h want %h", i, ifc.ext, exp); end end
      end
      if (ifc.in_valid && ifc.in_ready) sb.push_back(model(ifc.imm, ifc.mode));
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 8'h01, 2'b01, 1'b0);
    if (ifc.in_ready) sb.push_back(model(ifc.imm, ifc.mode));
    @(negedge clk);
    drive(1'b1, 8'h02, 2'b01, 1'b0);
    if (ifc.in_ready) sb.push_back(model(ifc.imm, ifc.mode));
    @(negedge clk);
    drive(1'b0, 8'h00, 2'b00, 1'b0);
    compared++; if (ifc.in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready_low: got %b want 0", ifc.in_ready); end
    compared++; if (ifc.out_valid !== 1'b1 || ifc.ext !== 32'h1) begin mismatched++; $display("FAIL bp_hold: valid=%b out=%h want 1/00000001", ifc.out_valid, ifc.ext); end
    @(negedge clk);
    compared++; if (ifc.ext !== 32'h1) begin mismatched++; $display("FAIL bp_stable: got %h want 00000001", ifc.ext); end
    drive(1'b0, 8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        compared++; if (ifc.ext !== 32'h2) begin mismatched++; $display("FAIL bp_skid_out: got %h want 00000002", ifc.ext); end
        compared++; if (ifc.in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_in_ready_back: got %b want 1", ifc.in_ready); end
      end
      if (ifc.out_valid && ifc.out_ready) begin
        compared++;
        if (sb.size() == 0) begin mismatched++; $display("FAIL bp_extra: got %h want no output", ifc.ext); end
        else begin exp = sb.pop_front(); if (ifc.ext !== exp) begin mismatched++; $display("FAIL bp_value: got %h want %h", ifc.ext, exp); end end
      end
      @(negedge clk);
    end
    compared++; if (ifc.out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drained: out_valid=%b want 0", ifc.out_valid); end
    compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL bp_lost: pending=%0d want 0", sb.size()); end
  endtask

  task automatic test_random();
    logic        stalled = 1'b0;
    logic [31:0] held    = '0;
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), 2'($urandom), $urandom_range(0, 9) < 6);
      compared++; if (ifc.out_valid !== (sb.size() != 0)) begin mismatched++; $display("FAIL rand_out_valid[%0d]: got %b want %b", i, ifc.out_valid, (sb.size() != 0)); end
      compared++; if (ifc.in_ready !== (sb.size() < 2)) begin mismatched++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, ifc.in_ready, (sb.size() < 2)); end
      compared++; if (sb.size() > 2) begin mismatched++; $display("FAIL rand_occupancy[%0d]: got %0d want <=2", i, sb.size()); end
      if (stalled) begin
        compared++; if (ifc.ext !== held) begin mismatched++; $display("FAIL rand_stall_stable[%0d]: got %h want %h", i, ifc.ext, held); end
      end
      if (ifc.out_valid && ifc.out_ready) begin
        compared++;
        if (sb.size() == 0) begin mismatched++; $display("FAIL rand_extra[%0d]: got %h want no output", i, ifc.ext); end
        else begin exp = sb.pop_front(); if (ifc.ext !== exp) begin mismatched++; $display("FAIL rand_value[%0d]: got %h want %h", i, ifc.ext, exp); end end
      end
      if (ifc.in_valid && ifc.in_ready) sb.push_back(model(ifc.imm, ifc.mode));
      stalled = ifc.out_valid && !ifc.out_ready;
      held    = ifc.ext;
      @(negedge clk);
    end
    drive(1'b0, 8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (ifc.out_valid && ifc.out_ready) begin
        compared++;
        if (sb.size() == 0) begin mismatched++; $display("FAIL drain_extra: got %h want no output", ifc.ext); end
        else begin exp = sb.pop_front(); if (ifc.ext !== exp) begin mismatched++; $display("FAIL drain_value: got %h want %h", ifc.ext, exp); end end
      end
      @(negedge clk);
    end
    compared++; if (sb.size() != 0 || ifc.out_valid !== 1'b0) begin mismatched++; $display("FAIL rand_lost: pending=%0d out_valid=%b want 0/0", sb.size(), ifc.out_valid); end
  endtask

  task automatic test_param_sweep();
    logic [11:0] d_t[2] = '{12'h800, 12'h7FF};
    logic [1:0]  m_t[2] = '{2'b10, 2'b00};
    logic [15:0] e_t[2] = '{16'h8000, 16'h07FF};
    logic [15:0] exp_w;
    for (int i = 0; i < 2; i++) begin
      ifc_w.in_valid = 1'b1; ifc_w.imm = d_t[i]; ifc_w.mode = m_t[i]; ifc_w.out_ready = 1'b1;
      if (ifc_w.in_ready) sb_w.push_back(e_t[i]);
      @(negedge clk);
      ifc_w.in_valid = 1'b0;
      compared++; if (ifc_w.out_valid !== 1'b1) begin mismatched++; $display("FAIL sweep%0d_latency: out_valid=%b want 1", i, ifc_w.out_valid); end
      if (ifc_w.out_valid && ifc_w.out_ready) begin
        compared++;
        if (sb_w.size() == 0) begin mismatched++; $display("FAIL sweep%0d_extra: got %h want no output", i, ifc_w.ext); end
        else begin exp_w = sb_w.pop_front(); if (ifc_w.ext !== exp_w) begin mismatched++; $display("FAIL sweep%0d_value: got %h want %h", i, ifc_w.ext, exp_w); end end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension stage for the processor datapath. It widens an IN_WIDTH-bit immediate or offset field to OUT_WIDTH bits by sign- or zero-extension, with an optional left shift by SHIFT for word-aligned branch and jump offsets. It sits between the decode stage and the ALU/PC-adder operand muxes, with a valid/ready handshake on both sides. A two-entry output buffer (output register plus skid register) provides full throughput and a registered IN_READY.

## Interface
- IN_WIDTH, 8, width of the immediate field.
- OUT_WIDTH, 32, width of the extended result. Must satisfy OUT_WIDTH >= IN_WIDTH + SHIFT.
- SHIFT, 2, left-shift amount used by the shifted modes.
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- IN  input  IN_WIDTH  immediate field from decode.
- MODE  input  2  extension mode:
  - 00: sign-extend.
  - 01: zero-extend.
  - 10: sign-extend, then shift left by SHIFT.
  - 11: zero-extend, then shift left by SHIFT.
- IN_VALID  input  1  IN and MODE are valid this cycle.
- IN_READY  output  1  block can accept an input. Registered. Reset value 1.
- OUT  output  OUT_WIDTH  extended result. Reset value 0.
- OUT_VALID  output  1  OUT holds a result. Reset value 0.
- OUT_READY  input  1  consumer accepts OUT this cycle.

## Operation
- Input transfer: IN_VALID && IN_READY at a rising edge. Output transfer: OUT_VALID && OUT_READY at a rising edge.
- Extension is combinational on the accepted input. MODE is sampled together with IN at the input transfer. The result is written to the output register or the skid register, never to both.
- Sign-extend replicates IN[IN_WIDTH-1] into bits OUT_WIDTH-1..IN_WIDTH. Zero-extend fills those bits with 0.
- Shifted modes shift the extended value left by SHIFT and fill the vacated LSBs with 0. No significant bits are lost, because of the width constraint.
- States (occupancy):
  - EMPTY: OUT_VALID=0, skid empty.
  - ONE: OUT_VALID=1, skid empty.
  - TWO: OUT_VALID=1, skid full.
- Transitions:
  - EMPTY, input transfer: result into output register -> ONE.
  - EMPTY, no input: stay EMPTY.
  - ONE, input and output transfer together: output register reloads with the new result -> ONE.
  - ONE, input only (OUT_READY=0): result into skid -> TWO.
  - ONE, output only: -> EMPTY.
  - ONE, neither: hold.
  - TWO, OUT_READY=1: skid moves into output register -> ONE.
  - TWO, OUT_READY=0: hold.
  - No input is accepted in TWO.
- IN_READY is registered. It equals 0 exactly in state TWO and 1 otherwise, and is updated at the same edge as the state.
- OUT is stable while OUT_VALID=1 and OUT_READY=0.
- OUT keeps its last value when the block goes EMPTY; only OUT_VALID drops.
- RESET low, at any time including mid-transfer:
  - Immediately drives OUT=0, OUT_VALID=0, IN_READY=1, state EMPTY.
  - Discards the buffered entries.
  - No transfer occurs while RESET is low.

## Timing
- Latency: 1 cycle. An input accepted at edge k gives OUT_VALID=1 with its result after edge k.
- Throughput: one result per cycle while OUT_READY=1.
- The second back-to-back input under backpressure is accepted. IN_READY then reads 0 starting the cycle after that acceptance.
- After OUT_READY returns high in TWO, IN_READY reads 1 one cycle later. The skid entry is presented at OUT in that same cycle.
- Results leave in acceptance order. There are no bubbles while a result is pending and OUT_READY=1.
- The first transfer is possible at the first rising edge after RESET deasserts.

## Test plan
- Reset: assert RESET low mid-stream in state TWO -> OUT=0, OUT_VALID=0, IN_READY=1 before the next edge. The skid data is never emitted.
- Modes, defaults, OUT_READY=1:
  - IN=8'h80, MODE 00 -> 32'hFFFFFF80; MODE 01 -> 32'h00000080; MODE 10 -> 32'hFFFFFE00; MODE 11 -> 32'h00000200.
  - IN=8'hFC, MODE 10 -> 32'hFFFFFFF0.
  - Each result appears one cycle after acceptance.
- Streaming: 16 back-to-back inputs with OUT_READY held at 1 -> 16 results on consecutive cycles, in order, with IN_READY constantly 1.
- Backpressure:
  - OUT_READY=0; feed 8'h01 then 8'h02 (MODE 01) -> both accepted, IN_READY=0 afterwards, OUT holds 32'h00000001.
  - Raise OUT_READY -> 32'h00000002 on the next cycle, IN_READY=1 one cycle later, no data lost or duplicated.
- Random valid/ready: randomised IN_VALID, OUT_READY, IN and MODE over 10k cycles, checked against a queue-based reference model. Required: no loss, reordering or duplication; OUT stable under stall; state never exceeds two entries.
- Parameter sweep: IN_WIDTH=12, OUT_WIDTH=16, SHIFT=4 with IN=12'h800, MODE 10 -> 16'h8000; IN=12'h7FF, MODE 00 -> 16'h07FF.
